ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the ID-stage control unit.
- Decodes the ARM-subset instruction held in IF/ID into a packed control bundle.
- Carries the bundle and destination register through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and applies stall/flush bubbles. Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- RF_AW, 4, register-address width (RF has 2**RF_AW entries).
- HAZARD_DET, 1, 1 = internal load-use detector active; 0 = hazard_stall tied 0.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ir  in  32  instruction in IF/ID
- cond_true  in  1  condition-test result for ir
- stall_in  in  1  external stall request
- flush  in  1  squash instruction in ID (branch taken)
- id_branch  out  1  combinational: ID holds a valid, condition-passed branch
- hazard_stall  out  1  combinational: load-use stall; IF/ID and PC must hold
- ex_ctrl  out  CTRL_W  ID/EX control bundle
- ex_rd  out  RF_AW  ID/EX destination register
- mem_ctrl  out  CTRL_W  EX/MEM bundle
- mem_rd  out  RF_AW  EX/MEM destination register
- wb_ctrl  out  CTRL_W  MEM/WB bundle
- wb_rd  out  RF_AW  MEM/WB destination register

Behaviour:
- Reset: all *_ctrl and *_rd registers are 0 immediately on rst_n low, mid-operation included.
- Bundle (CTRL_W=16): [15]s [14:11]op [10:9]sm [8:7]mm [6]load [5]b [4]rf [3]rw [2]data [1]shift_imm [0]valid.
- Bubble = all-zero bundle, rd=0.
- Decode (combinational, ID):
  - Bubble when ir==0 or cond_true==0.
  - DP, ir[27:26]==00 and (ir[25] or !ir[4]):
    - op=ir[24:21], s=ir[20], rd=ir[15:12], valid=1.
    - sm=00 if ir[25], else 01.
    - shift_imm = ir[25] | (ir[11:4]!=0).
    - rf = 0 for op 10xx, else 1.
  - LS, ir[27:26]==01, ir[24]==1, ir[21]==0, (!ir[25] or !ir[4]):
    - op=0100 if ir[23], else 0010.
    - sm=10 if !ir[25], else 11.
    - mm=00 if ir[22] (byte), else 10.
    - load=rf=ir[20], rw=!ir[20], data=1, rd=ir[15:12].
    - shift_imm = !ir[25] | (ir[11:4]!=0).
  - Branch, ir[27:25]==101: b=1, valid=1, all else 0.
  - Anything else: bubble.
- Sources used:
  - Rn=ir[19:16] for DP except op 1101/1111, and for all LS.
  - Rm=ir[3:0] for DP with !ir[25] and LS with ir[25].
  - Rd for LS store.
- hazard_stall = HAZARD_DET & ex_ctrl.valid & ex_ctrl.load & decoded-valid & (ex_rd matches any used source).
- Posedge update:
  - ID/EX loads bubble if flush | stall_in | hazard_stall, otherwise the decoded bundle.
  - flush has priority, and ID/EX stays a bubble even when stall_in is set.
  - EX/MEM <= ID/EX and MEM/WB <= EX/MEM unconditionally; downstream never stalls.
- Latency: decoded bundle visible on ex_* 1 cycle after ir, mem_* 2 cycles, wb_* 3 cycles.
- id_branch = decoded b & valid; not gated by stall.

Optional Feature:
- CTRL_LINK_EN defined: branch with ir[24]=1 (BL) decodes rf=1, rd=4'd14, op=0100, sm=00; valid, b=1.
- Undefined: BL decodes identically to B, with rf=0 and rd=0.

Decomposition:
- Package ctrl_pkg holds:
  - CTRL_W and the bundle field bit positions.
  - CTRL_BUBBLE.
  - SM_*/MM_* encodings (SM_IMM=00, SM_REG=01, SM_LS_IMM=10, SM_LS_REG=11; MM_BYTE=00, MM_WORD=10).
  - OP_ADD/OP_SUB.
- One sub-module, ctrl_decode, for the combinational decoder and source-use flags.
- ctrl_pipe instantiates it and holds the registers and hazard logic.

Test Plan:
- Reset: rst_n low mid-stream -> ex/mem/wb_ctrl and *_rd equal 0 asynchronously and stay 0 until the first edge after release.
- ADD R1,R2,#5 (E2821005), cond_true=1 -> next cycle ex_ctrl op=0100, sm=00, rf=1, shift_imm=1, valid=1, ex_rd=1; the same bundle appears on mem_* one cycle later and on wb_* two cycles later.
- LDR R3,[R1,#4] (E5913004) then ADD R4,R3,R3 (E0834003):
  - hazard_stall=1 for exactly one cycle and EX receives a bubble.
  - ADD reaches ex_ctrl one cycle later.
  - With HAZARD_DET=0, no stall.
- STRB R2,[R1,-R0] (E7412000) -> op=0010, sm=11, mm=00, rw=1, rf=0, data=1, shift_imm=0.
- B (EA000002) -> id_branch=1; with flush=1 on that cycle, ex_ctrl=0. BL (EB000002) with CTRL_LINK_EN -> rf=1, ex_rd=14.
- cond_true=0 on E2821005, ir=0, or unsupported ir=E0812091 (ir[4]=1) -> ex_ctrl=0 and id_branch=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ID-stage control pipeline.
// Optional feature macro: CTRL_LINK_EN (BL writes the link register).
package ctrl_pkg;

  localparam int unsigned CTRL_W = 16;

  localparam int unsigned B_S         = 15;
  localparam int unsigned B_OP_HI     = 14;
  localparam int unsigned B_OP_LO     = 11;
  localparam int unsigned B_SM_HI     = 10;
  localparam int unsigned B_SM_LO     = 9;
  localparam int unsigned B_MM_HI     = 8;
  localparam int unsigned B_MM_LO     = 7;
  localparam int unsigned B_LOAD      = 6;
  localparam int unsigned B_B         = 5;
  localparam int unsigned B_RF        = 4;
  localparam int unsigned B_RW        = 3;
  localparam int unsigned B_DATA      = 2;
  localparam int unsigned B_SHIFT_IMM = 1;
  localparam int unsigned B_VALID     = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  localparam logic [1:0] SM_IMM    = 2'b00;
  localparam logic [1:0] SM_REG    = 2'b01;
  localparam logic [1:0] SM_LS_IMM = 2'b10;
  localparam logic [1:0] SM_LS_REG = 2'b11;
  localparam logic [1:0] MM_BYTE   = 2'b00;
  localparam logic [1:0] MM_WORD   = 2'b10;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0010;

  typedef struct packed {
    logic       s;
    logic [3:0] op;
    logic [1:0] sm;
    logic [1:0] mm;
    logic       load;
    logic       b;
    logic       rf;
    logic       rw;
    logic       data;
    logic       shift_imm;
    logic       valid;
  } ctrl_t;

  // Flatten a bundle onto the bus layout using the named bit positions.
  function automatic logic [CTRL_W-1:0] to_vec(input ctrl_t c);
    logic [CTRL_W-1:0] v;
    v                     = CTRL_BUBBLE;
    v[B_S]                = c.s;
    v[B_OP_HI:B_OP_LO]    = c.op;
    v[B_SM_HI:B_SM_LO]    = c.sm;
    v[B_MM_HI:B_MM_LO]    = c.mm;
    v[B_LOAD]             = c.load;
    v[B_B]                = c.b;
    v[B_RF]               = c.rf;
    v[B_RW]               = c.rw;
    v[B_DATA]             = c.data;
    v[B_SHIFT_IMM]        = c.shift_imm;
    v[B_VALID]            = c.valid;
    return v;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: control bundle, destination and source-use flags.
// Optional feature macro: CTRL_LINK_EN (BL decodes as a link-register write).
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned RF_AW = 4
) (
  input  logic [31:0]       ir,
  input  logic              cond_true,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RF_AW-1:0]  rd,
  output logic [RF_AW-1:0]  rn,
  output logic [RF_AW-1:0]  rm,
  output logic              use_rn,
  output logic              use_rm,
  output logic              use_rd
);

  ctrl_t c;

  assign rn   = RF_AW'(ir[19:16]);
  assign rm   = RF_AW'(ir[3:0]);
  assign ctrl = to_vec(c);

  always_comb begin
    c      = ctrl_t'(CTRL_BUBBLE);
    rd     = '0;
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rd = 1'b0;
    if (ir != 32'd0 && cond_true) begin
      if (ir[27:26] == 2'b00 && (ir[25] || !ir[4])) begin
        c.op        = ir[24:21];
        c.s         = ir[20];
        c.sm        = ir[25] ? SM_IMM : SM_REG;
        c.shift_imm = ir[25] | (ir[11:4] != 8'd0);
        c.rf        = (ir[24:23] != 2'b10);
        c.valid     = 1'b1;
        rd          = RF_AW'(ir[15:12]);
        // MOV/MVN take no first operand
        use_rn      = (ir[24:21] != 4'b1101) && (ir[24:21] != 4'b1111);
        use_rm      = !ir[25];
      end else if (ir[27:26] == 2'b01 && ir[24] && !ir[21] && (!ir[25] || !ir[4])) begin
        c.op        = ir[23] ? OP_ADD : OP_SUB;
        c.sm        = ir[25] ? SM_LS_REG : SM_LS_IMM;
        c.mm        = ir[22] ? MM_BYTE : MM_WORD;
        c.load      = ir[20];
        c.rf        = ir[20];
        c.rw        = !ir[20];
        c.data      = 1'b1;
        c.shift_imm = !ir[25] | (ir[11:4] != 8'd0);
        c.valid     = 1'b1;
        rd          = RF_AW'(ir[15:12]);
        use_rn      = 1'b1;
        use_rm      = ir[25];
        use_rd      = !ir[20];
      end else if (ir[27:25] == 3'b101) begin
        c.b     = 1'b1;
        c.valid = 1'b1;
`ifdef CTRL_LINK_EN
        if (ir[24]) begin
          c.rf = 1'b1;
          c.op = OP_ADD;
          c.sm = SM_IMM;
          rd   = RF_AW'(4'd14);
        end
`endif
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage control pipeline: decode, load-use hazard stall, ID/EX..MEM/WB registers.
// Optional feature macro: CTRL_LINK_EN (handled inside ctrl_decode).
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned RF_AW      = 4,
  parameter bit          HAZARD_DET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ir,
  input  logic              cond_true,
  input  logic              stall_in,
  input  logic              flush,
  output logic              id_branch,
  output logic              hazard_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RF_AW-1:0]  ex_rd,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [RF_AW-1:0]  mem_rd,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RF_AW-1:0]  wb_rd
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [RF_AW-1:0]  dec_rd;
  logic [RF_AW-1:0]  dec_rn;
  logic [RF_AW-1:0]  dec_rm;
  logic              use_rn;
  logic              use_rm;
  logic              use_rd;
  logic              src_hit;
  logic              bubble;

  ctrl_decode #(.RF_AW(RF_AW)) u_decode (
    .ir        (ir),
    .cond_true (cond_true),
    .ctrl      (dec_ctrl),
    .rd        (dec_rd),
    .rn        (dec_rn),
    .rm        (dec_rm),
    .use_rn    (use_rn),
    .use_rm    (use_rm),
    .use_rd    (use_rd)
  );

  assign id_branch = dec_ctrl[B_B] & dec_ctrl[B_VALID];

  // A load in EX whose target feeds any operand of the ID instruction
  assign src_hit = (use_rn && dec_rn == ex_rd) ||
                   (use_rm && dec_rm == ex_rd) ||
                   (use_rd && dec_rd == ex_rd);

  assign hazard_stall = HAZARD_DET && ex_ctrl[B_VALID] && ex_ctrl[B_LOAD] &&
                        dec_ctrl[B_VALID] && src_hit;

  assign bubble = flush | stall_in | hazard_stall;

  // Only ID/EX can bubble; later stages always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= CTRL_BUBBLE;
      ex_rd    <= '0;
      mem_ctrl <= CTRL_BUBBLE;
      mem_rd   <= '0;
      wb_ctrl  <= CTRL_BUBBLE;
      wb_rd    <= '0;
    end else begin
      ex_ctrl  <= bubble ? CTRL_BUBBLE : dec_ctrl;
      ex_rd    <= bubble ? '0 : dec_rd;
      mem_ctrl <= ex_ctrl;
      mem_rd   <= ex_rd;
      wb_ctrl  <= mem_ctrl;
      wb_rd    <= mem_rd;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: randomized and directed instructions vs a reference decoder.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        cond_true = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;

  logic        id_branch, hazard_stall;
  logic [15:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [3:0]  ex_rd, mem_rd, wb_rd;

  logic        nh_id_branch, nh_hazard_stall;
  logic [15:0] nh_ex_ctrl, nh_mem_ctrl, nh_wb_ctrl;
  logic [3:0]  nh_ex_rd, nh_mem_rd, nh_wb_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.RF_AW(4), .HAZARD_DET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true),
    .stall_in(stall_in), .flush(flush),
    .id_branch(id_branch), .hazard_stall(hazard_stall),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd)
  );

  ctrl_pipe #(.RF_AW(4), .HAZARD_DET(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true),
    .stall_in(stall_in), .flush(flush),
    .id_branch(nh_id_branch), .hazard_stall(nh_hazard_stall),
    .ex_ctrl(nh_ex_ctrl), .ex_rd(nh_ex_rd), .mem_ctrl(nh_mem_ctrl), .mem_rd(nh_mem_rd),
    .wb_ctrl(nh_wb_ctrl), .wb_rd(nh_wb_rd)
  );

  typedef struct {
    logic [15:0] ctrl;
    logic [3:0]  rd;
    logic [15:0] srcs;   // one bit per register the instruction reads
  } mdec_t;

  typedef struct packed { logic br; logic hz; } cexp_t;
  typedef struct packed {
    logic [15:0] ex;  logic [3:0] exrd;
    logic [15:0] mem; logic [3:0] memrd;
    logic [15:0] wb;  logic [3:0] wbrd;
  } rexp_t;

  cexp_t cq[$];
  rexp_t rq[$];

  logic [15:0] m_ex = 16'd0, m_mem = 16'd0, m_wb = 16'd0;
  logic [3:0]  m_exrd = 4'd0, m_memrd = 4'd0, m_wbrd = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder built straight from the instruction-class rules
  function automatic mdec_t mdecode(input logic [31:0] i, input logic c);
    mdec_t d;
    logic s, load, b, rf, rw, data, shi, v;
    logic [3:0] op;
    logic [1:0] sm, mm;
    d.ctrl = 16'd0; d.rd = 4'd0; d.srcs = 16'd0;
    {s, load, b, rf, rw, data, shi, v} = 8'd0;
    op = 4'd0; sm = 2'd0; mm = 2'd0;
    if (i == 32'd0 || !c) return d;
    if (i[27:26] == 2'b00 && (i[25] || !i[4])) begin
      op = i[24:21]; s = i[20]; v = 1'b1; d.rd = i[15:12];
      sm = i[25] ? 2'b00 : 2'b01;
      shi = i[25] || (i[11:4] != 8'd0);
      rf = !(op == 4'b1000 || op == 4'b1001 || op == 4'b1010 || op == 4'b1011);
      if (op != 4'hD && op != 4'hF) d.srcs[i[19:16]] = 1'b1;
      if (!i[25]) d.srcs[i[3:0]] = 1'b1;
    end else if (i[27:26] == 2'b01 && i[24] && !i[21] && (!i[25] || !i[4])) begin
      op = i[23] ? 4'b0100 : 4'b0010;
      sm = i[25] ? 2'b11 : 2'b10;
      mm = i[22] ? 2'b00 : 2'b10;
      load = i[20]; rf = i[20]; rw = !i[20]; data = 1'b1; v = 1'b1;
      shi = !i[25] || (i[11:4] != 8'd0);
      d.rd = i[15:12];
      d.srcs[i[19:16]] = 1'b1;
      if (i[25]) d.srcs[i[3:0]] = 1'b1;
      if (!i[20]) d.srcs[i[15:12]] = 1'b1;
    end else if (i[27:25] == 3'b101) begin
      b = 1'b1; v = 1'b1;
`ifdef CTRL_LINK_EN
      if (i[24]) begin rf = 1'b1; d.rd = 4'd14; op = 4'b0100; end
`endif
    end
    d.ctrl = {s, op, sm, mm, load, b, rf, rw, data, shi, v};
    return d;
  endfunction

  // Drive one ID cycle and record what the DUT must show now and after the next edge
  task automatic step(input logic [31:0] i, input logic c, input logic s, input logic f);
    mdec_t d;
    logic hz;
    @(negedge clk);
    ir = i; cond_true = c; stall_in = s; flush = f;
    d = mdecode(i, c);
    hz = m_ex[6] && m_ex[0] && d.ctrl[0] && d.srcs[m_exrd];
    cq.push_back('{br: d.ctrl[5] & d.ctrl[0], hz: hz});
    m_wb = m_mem;  m_wbrd = m_memrd;
    m_mem = m_ex;  m_memrd = m_exrd;
    if (f || s || hz) begin m_ex = 16'd0; m_exrd = 4'd0; end
    else begin m_ex = d.ctrl; m_exrd = d.rd; end
    rq.push_back('{ex: m_ex, exrd: m_exrd, mem: m_mem, memrd: m_memrd, wb: m_wb, wbrd: m_wbrd});
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [11:0] lo;
    int k;
    k = int'($urandom_range(0, 9));
    lo = 12'($urandom);
    lo[3:0] = 4'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) lo[4] = 1'b0;
    if ($urandom_range(0, 3) == 0) lo[11:4] = 8'd0;
    if (k <= 3)
      r = {4'hE, 2'b00, 1'($urandom), 4'($urandom), 1'($urandom),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), lo};
    else if (k <= 6)
      r = {4'hE, 2'b01, 1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), 1'($urandom),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), lo};
    else if (k == 7)
      r = {4'hE, 3'b101, 1'($urandom), 24'($urandom)};
    else if (k == 8)
      r = 32'd0;
    else
      r = $urandom;
    return r;
  endfunction

  // Combinational outputs, checked mid-cycle after the inputs settle
  initial forever begin
    cexp_t ce;
    @(negedge clk); #1;
    if (cq.size() > 0) begin
      ce = cq.pop_front();
      chk("id_branch", 32'(id_branch), 32'(ce.br));
      chk("hazard_stall", 32'(hazard_stall), 32'(ce.hz));
      chk("nodet_hazard_stall", 32'(nh_hazard_stall), 32'd0);
    end
  end

  // Pipeline registers, checked just after the edge
  initial forever begin
    rexp_t re;
    @(posedge clk); #1;
    if (rq.size() > 0) begin
      re = rq.pop_front();
      chk("ex_ctrl", 32'(ex_ctrl), 32'(re.ex));
      chk("ex_rd", 32'(ex_rd), 32'(re.exrd));
      chk("mem_ctrl", 32'(mem_ctrl), 32'(re.mem));
      chk("mem_rd", 32'(mem_rd), 32'(re.memrd));
      chk("wb_ctrl", 32'(wb_ctrl), 32'(re.wb));
      chk("wb_rd", 32'(wb_rd), 32'(re.wbrd));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string name);
    chk(name, 32'({ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd}), 32'd0);
    chk({name, "_hi"}, 32'({ex_ctrl, mem_ctrl}), 32'd0);
  endtask

  initial begin
    logic [15:0] bl_ctrl;
    logic [3:0]  bl_rd;
`ifdef CTRL_LINK_EN
    bl_ctrl = 16'h2031; bl_rd = 4'd14;
`else
    bl_ctrl = 16'h0021; bl_rd = 4'd0;
`endif
    #1;
    chk_all_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1,R2,#5 through all three stages
    step(32'hE2821005, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("add_ex_ctrl", 32'(ex_ctrl), 32'h2013);
    chk("add_ex_rd", 32'(ex_rd), 32'd1);
    step(32'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("add_mem_ctrl", 32'(mem_ctrl), 32'h2013);
    chk("add_mem_rd", 32'(mem_rd), 32'd1);
    step(32'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("add_wb_ctrl", 32'(wb_ctrl), 32'h2013);
    chk("add_wb_rd", 32'(wb_rd), 32'd1);

    // LDR R3,[R1,#4] then dependent ADD R4,R3,R3 held in IF/ID across the stall
    step(32'hE5913004, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ldr_ex_ctrl", 32'(ex_ctrl), 32'h2557);
    step(32'hE0834003, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall_on", 32'(hazard_stall), 32'd1);
    chk("lu_nodet_stall", 32'(nh_hazard_stall), 32'd0);
    @(posedge clk); #1;
    chk("lu_bubble", 32'(ex_ctrl), 32'd0);
    chk("lu_nodet_ex", 32'(nh_ex_ctrl), 32'h2211);
    step(32'hE0834003, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall_off", 32'(hazard_stall), 32'd0);
    @(posedge clk); #1;
    chk("lu_add_ex", 32'(ex_ctrl), 32'h2211);
    chk("lu_add_rd", 32'(ex_rd), 32'd4);

    // STRB R2,[R1,-R0]
    step(32'hE7412000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("strb_ex_ctrl", 32'(ex_ctrl), 32'h160D);
    chk("strb_ex_rd", 32'(ex_rd), 32'd2);

    // Branch, flushed branch, BL
    step(32'hEA000002, 1'b1, 1'b0, 1'b0);
    #1;
    chk("b_id_branch", 32'(id_branch), 32'd1);
    @(posedge clk); #1;
    chk("b_ex_ctrl", 32'(ex_ctrl), 32'h0021);
    step(32'hEA000002, 1'b1, 1'b1, 1'b1);
    #1;
    chk("bf_id_branch", 32'(id_branch), 32'd1);
    @(posedge clk); #1;
    chk("bf_ex_ctrl", 32'(ex_ctrl), 32'd0);
    step(32'hEB000002, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bl_ex_ctrl", 32'(ex_ctrl), 32'(bl_ctrl));
    chk("bl_ex_rd", 32'(ex_rd), 32'(bl_rd));

    // Condition failed, zero word, unsupported register-shifted DP
    step(32'hE2821005, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cf_id_branch", 32'(id_branch), 32'd0);
    @(posedge clk); #1;
    chk("cf_ex_ctrl", 32'(ex_ctrl), 32'd0);
    step(32'h00000000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("zero_ex_ctrl", 32'(ex_ctrl), 32'd0);
    step(32'hE0812091, 1'b1, 1'b0, 1'b0);
    #1;
    chk("unsup_id_branch", 32'(id_branch), 32'd0);
    @(posedge clk); #1;
    chk("unsup_ex_ctrl", 32'(ex_ctrl), 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++)
      step(rand_ir(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0));

    // Asynchronous reset mid-stream
    step(32'hE2821005, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    ir = 32'hE2821005; cond_true = 1'b1; stall_in = 1'b0; flush = 1'b0;
    #1;
    chk_all_zero("reset_release");
    @(posedge clk); #1;
    chk("post_reset_ex", 32'(ex_ctrl), 32'h2013);
    m_ex = 16'h2013; m_exrd = 4'd1;
    m_mem = 16'd0; m_memrd = 4'd0; m_wb = 16'd0; m_wbrd = 4'd0;

    for (int n = 0; n < 100; n++)
      step(rand_ir(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0));

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
